// File: rtl/cla_pipe_pkg.sv
// Shared op encodings and sizing helpers for the pipelined CLA ALU.
// Ports: none (package).
package cla_pipe_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_t;

    localparam int WIDTH_DEF = 16;
    localparam int GROUP_DEF = 4;
    localparam int NGROUPS   = WIDTH_DEF / GROUP_DEF;

    function automatic int ngroups(input int w, input int g);
        return w / g;
    endfunction

endpackage

// File: rtl/cla_pipe_alu_if.sv
// Request/result bundle between datapath and the CLA ALU.
// master: drives enable/in_valid/op/A/B/Cin; slave: drives Q/flags/out_valid.
interface cla_pipe_alu_if #(
    parameter int WIDTH = 16
);
    import cla_pipe_pkg::*;

    logic             enable;
    logic             in_valid;
    op_t              op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] Q;
    logic             Cout;
    logic             Ovf;
    logic             Zero;
    logic             out_valid;

    modport master (
        output enable, in_valid, op, A, B, Cin,
        input  Q, Cout, Ovf, Zero, out_valid
    );

    modport slave (
        input  enable, in_valid, op, A, B, Cin,
        output Q, Cout, Ovf, Zero, out_valid
    );

endinterface

// File: rtl/cla_group.sv
// GROUP-bit lookahead slice: sum bits plus group generate/propagate.
// Ports: i_a/i_b operands, i_c carry in, o_s sum, o_g/o_p group G/P.
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] i_a,
    input  logic [GROUP-1:0] i_b,
    input  logic             i_c,
    output logic [GROUP-1:0] o_s,
    output logic             o_g,
    output logic             o_p
);

    logic [GROUP-1:0] w_g;
    logic [GROUP-1:0] w_p;
    logic [GROUP:0]   w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Group G/P kept independent of i_c so the second level
    // can resolve group carries without a combinational loop.
    always_comb begin : grp_gp
        o_g = w_g[0];
        for (int i = 1; i < GROUP; i++) begin
            o_g = w_g[i] | (w_p[i] & o_g);
        end
        o_p = &w_p;
    end

    always_comb begin : grp_sum
        w_c[0] = i_c;
        for (int i = 0; i < GROUP; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
        o_s = w_p ^ w_c[GROUP-1:0];
    end

endmodule

// File: rtl/cla_pipe_alu.sv
// Two-stage pipelined CLA add/sub/accumulate/clear with flags.
// Ports: clk, reset (async, active-high), bus (slave side of cla_pipe_alu_if).
module cla_pipe_alu
    import cla_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input logic         clk,
    input logic         reset,
    cla_pipe_alu_if.slave bus
);

    localparam int NG = WIDTH / GROUP;

    // Stage 1 registers
    logic             r_v1;
    op_t              r_op1;
    logic [WIDTH-1:0] r_a1;
    logic [WIDTH-1:0] r_b1;
    logic             r_c1;

    // Stage 2 / architectural result registers
    logic [WIDTH-1:0] r_q;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_ov;

    logic [WIDTH-1:0] w_opd2;
    logic [WIDTH-1:0] w_sum;
    logic [NG-1:0]    w_gg;
    logic [NG-1:0]    w_gp;
    logic [NG:0]      w_gc;
    logic             w_cmsb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1  <= 1'b0;
            r_op1 <= OP_ADD;
            r_a1  <= '0;
            r_b1  <= '0;
            r_c1  <= 1'b0;
        end else if (bus.enable) begin
            r_v1  <= bus.in_valid;
            r_op1 <= bus.op;
            r_a1  <= bus.A;
            r_b1  <= (bus.op == OP_SUB) ? ~bus.B : bus.B;
            r_c1  <= (bus.op == OP_SUB) ? 1'b1 : bus.Cin;
        end
    end

    // ACC feeds the live Q back, so back-to-back ACC needs no bubble.
    assign w_opd2 = (r_op1 == OP_ACC) ? r_q : r_b1;

    for (genvar j = 0; j < NG; j++) begin : g_grp
        cla_group #(.GROUP(GROUP)) u_grp (
            .i_a (r_a1[j*GROUP +: GROUP]),
            .i_b (w_opd2[j*GROUP +: GROUP]),
            .i_c (w_gc[j]),
            .o_s (w_sum[j*GROUP +: GROUP]),
            .o_g (w_gg[j]),
            .o_p (w_gp[j])
        );
    end

    always_comb begin : lvl2
        w_gc[0] = r_c1;
        for (int j = 0; j < NG; j++) begin
            w_gc[j+1] = w_gg[j] | (w_gp[j] & w_gc[j]);
        end
    end

    // Carry into MSB recovered from the MSB sum bit: s = a ^ b ^ c.
    assign w_cmsb = w_sum[WIDTH-1] ^ r_a1[WIDTH-1] ^ w_opd2[WIDTH-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q    <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b1;
            r_ov   <= 1'b0;
        end else if (bus.enable) begin
            if (r_v1) begin
                r_ov <= 1'b1;
                unique case (r_op1)
                    OP_CLR: begin
                        r_q    <= '0;
                        r_cout <= 1'b0;
                        r_ovf  <= 1'b0;
                        r_zero <= 1'b1;
                    end
                    default: begin
                        r_q    <= w_sum;
                        r_cout <= w_gc[NG];
                        r_ovf  <= w_cmsb ^ w_gc[NG];
                        r_zero <= (w_sum == '0);
                    end
                endcase
            end else begin
                r_ov <= 1'b0;
            end
        end
    end

    assign bus.Q         = r_q;
    assign bus.Cout      = r_cout;
    assign bus.Ovf       = r_ovf;
    assign bus.Zero      = r_zero;
    assign bus.out_valid = r_ov;

endmodule

// File: tb/tb_cla_pipe_alu.sv
// Directed-vector bench for cla_pipe_alu (WIDTH=16, GROUP=4).
// Drives the interface master side and checks Q/flags/out_valid.
module tb_cla_pipe_alu;
    import cla_pipe_pkg::*;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    cla_pipe_alu_if #(.WIDTH(16)) bus ();

    cla_pipe_alu #(.WIDTH(16), .GROUP(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [15:0] q,
                           input logic c, input logic o,
                           input logic z, input logic v);
        chk({tag, ".Q"},    bus.Q,                  q);
        chk({tag, ".Cout"}, {15'd0, bus.Cout},      {15'd0, c});
        chk({tag, ".Ovf"},  {15'd0, bus.Ovf},       {15'd0, o});
        chk({tag, ".Zero"}, {15'd0, bus.Zero},      {15'd0, z});
        chk({tag, ".ov"},   {15'd0, bus.out_valid}, {15'd0, v});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input op_t op, input logic [15:0] a,
                         input logic [15:0] b, input logic cin);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.A        = a;
        bus.B        = b;
        bus.Cin      = cin;
        step();
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        step();
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        reset        = 1'b1;
        bus.enable   = 1'b1;
        bus.in_valid = 1'b0;
        bus.op       = OP_ADD;
        bus.A        = '0;
        bus.B        = '0;
        bus.Cin      = 1'b0;
        step();
        step();
        chk_res("rst", 16'h0000, 0, 0, 1, 0);
        reset = 1'b0;
        step();

        // 1: plain add, single-cycle out_valid pulse
        issue(OP_ADD, 16'h1234, 16'h0FFF, 0);
        chk("t1.lat", {15'd0, bus.out_valid}, 16'd0);
        idle();
        chk_res("t1", 16'h2233, 0, 0, 0, 1);
        idle();
        chk("t1.pulse", {15'd0, bus.out_valid}, 16'd0);

        // 2: wrap to zero, then signed overflow
        issue(OP_ADD, 16'hFFFF, 16'h0001, 0);
        issue(OP_ADD, 16'h7FFF, 16'h0001, 0);
        chk_res("t2a", 16'h0000, 1, 0, 1, 1);
        idle();
        chk_res("t2b", 16'h8000, 0, 1, 0, 1);

        // 3: subtract with overflow, then with borrow
        issue(OP_SUB, 16'h8000, 16'h0001, 0);
        issue(OP_SUB, 16'h0003, 16'h0005, 0);
        chk_res("t3a", 16'h7FFF, 1, 1, 0, 1);
        idle();
        chk_res("t3b", 16'hFFFE, 0, 0, 0, 1);

        // 4: clear then back-to-back accumulate
        issue(OP_CLR, 16'h0000, 16'h0000, 0);
        issue(OP_ACC, 16'h0005, 16'hAAAA, 0);
        chk_res("t4clr", 16'h0000, 0, 0, 1, 1);
        issue(OP_ACC, 16'h0005, 16'h5555, 0);
        chk_res("t4a1", 16'h0005, 0, 0, 0, 1);
        issue(OP_ACC, 16'h0005, 16'hFFFF, 0);
        chk_res("t4a2", 16'h000A, 0, 0, 0, 1);
        idle();
        chk_res("t4a3", 16'h000F, 0, 0, 0, 1);
        idle();
        chk_res("t4end", 16'h000F, 0, 0, 0, 0);

        // 5: stall between stages; inputs during stall ignored
        issue(OP_ADD, 16'h0001, 16'h0001, 0);
        bus.enable   = 1'b0;
        bus.in_valid = 1'b1;
        bus.op       = OP_ADD;
        bus.A        = 16'hFFFF;
        bus.B        = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_res("t5stall", 16'h000F, 0, 0, 0, 0);
        end
        bus.enable = 1'b1;
        idle();
        chk_res("t5rel", 16'h0002, 0, 0, 0, 1);
        idle();
        chk_res("t5post", 16'h0002, 0, 0, 0, 0);

        // 6: async reset mid-cycle discards in-flight ops
        issue(OP_ADD, 16'h0100, 16'h0100, 0);
        bus.in_valid = 1'b1;
        bus.op       = OP_ADD;
        bus.A        = 16'h0200;
        bus.B        = 16'h0001;
        #2;
        reset = 1'b1;
        #1;
        chk_res("t6rst", 16'h0000, 0, 0, 1, 0);
        step();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_res("t6post", 16'h0000, 0, 0, 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
